// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK command encoding and per-bit excitation helper
package jk_pkg;

    // Encoding is {J,K}.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Excite only bits that change: set when rising, reset when falling.
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        return {nxt & ~cur, ~nxt & cur};
    endfunction

endpackage

// File: rtl/jk_ff_bank.sv
// rtl/jk_ff_bank.sv - WIDTH-wide bank of JK flip-flops with shared clk and async clear
module jk_ff_bank
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j[i], k[i]})
                    JK_SET:    q[i] <= 1'b1;
                    JK_RESET:  q[i] <= 1'b0;
                    JK_TOGGLE: q[i] <= ~q[i];
                    default:   q[i] <= q[i];
                endcase
            end
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter on a JK bank; JK_MOD_COUNTER_SATURATE_EN selects saturation
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             load_err
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

`ifdef JK_MOD_COUNTER_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load_err_n;
    logic             d_ok;
    logic             at_max;
    logic             at_min;

    assign d_ok   = ({1'b0, d} < MOD_W);
    assign at_max = (q == MAX_Q);
    assign at_min = (q == '0);

    always_comb begin
        n          = q;
        load_err_n = 1'b0;
        if (load) begin
            // A rejected load also swallows the count for this edge.
            if (d_ok) n = d;
            else      load_err_n = 1'b1;
        end else if (en) begin
            if (up) n = at_max ? (SATURATE ? q : '0) : q + ONE;
            else    n = at_min ? (SATURATE ? q : MAX_Q) : q - ONE;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_excite
        assign {j[i], k[i]} = jk_excite(q[i], n[i]);
    end

    jk_ff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk (clk),
        .clr (clr),
        .j   (j),
        .k   (k),
        .q   (q),
        .qb  (qb)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) load_err <= 1'b0;
        else      load_err <= load_err_n;
    end

    assign tc = en & ~load & ((up & at_max) | (~up & at_min));

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - randomized self-checking bench for jk_mod_counter
module tb_jk_mod_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

`ifdef JK_MOD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             en = 1'b0;
    logic             up = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;
    logic             load_err;

    int n_cmp = 0;
    int n_bad = 0;
    int mq    = 0;
    int merr  = 0;

    jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .up       (up),
        .load     (load),
        .d        (d),
        .q        (q),
        .qb       (qb),
        .tc       (tc),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int cq);
        int dv;
        dv = int'(d);
        if (load) return (dv < MODULUS) ? dv : cq;
        if (!en) return cq;
        if (up) begin
            if (cq == MODULUS - 1) return SAT ? cq : 0;
            return cq + 1;
        end
        if (cq == 0) return SAT ? 0 : MODULUS - 1;
        return cq - 1;
    endfunction

    // Inputs are already applied by the caller; checks straddle one rising edge.
    task automatic do_cycle(input string tag);
        int nx;
        int exp_tc;
        #1;
        nx = model_next(mq);
        exp_tc = (en && !load && ((up && mq == MODULUS - 1) || (!up && mq == 0))) ? 1 : 0;
        check_val({tag, ".tc"}, int'(tc), exp_tc);
        check_val({tag, ".j"}, int'(dut.j), nx & ~mq & ((1 << WIDTH) - 1));
        check_val({tag, ".k"}, int'(dut.k), ~nx & mq & ((1 << WIDTH) - 1));
        @(posedge clk);
        mq   = nx;
        merr = (load && int'(d) >= MODULUS) ? 1 : 0;
        #1;
        check_val({tag, ".q"}, int'(q), mq);
        check_val({tag, ".qb"}, int'(qb), (~mq) & ((1 << WIDTH) - 1));
        check_val({tag, ".load_err"}, int'(load_err), merr);
    endtask

    task automatic drive(input logic l, input logic [WIDTH-1:0] dv, input logic e, input logic u);
        load = l;
        d    = dv;
        en   = e;
        up   = u;
    endtask

    initial begin
        #2;
        check_val("rst.q", int'(q), 0);
        check_val("rst.qb", int'(qb), 15);
        check_val("rst.load_err", int'(load_err), 0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        mq  = 0;

        // Async clear mid-count with a pending load error.
        drive(1'b1, 4'd7, 1'b0, 1'b1);  do_cycle("ld7");
        drive(1'b1, 4'd12, 1'b1, 1'b1); do_cycle("ld12");
        #2;
        clr = 1'b0;
        #1;
        check_val("aclr.q", int'(q), 0);
        check_val("aclr.qb", int'(qb), 15);
        check_val("aclr.load_err", int'(load_err), 0);
        mq = 0;
        drive(1'b0, 4'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_val("aclr_hold.q", int'(q), 0);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle("resume");
        check_val("resume3.q", int'(q), 3);

        // Up wrap / saturate at MODULUS-1.
        drive(1'b1, 4'd8, 1'b0, 1'b1); do_cycle("ld8");
        drive(1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) do_cycle("upwrap");

        // Down wrap / saturate at 0.
        drive(1'b1, 4'd0, 1'b0, 1'b0); do_cycle("ld0");
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle("dnwrap");

        // Load priority and rejected load.
        drive(1'b1, 4'd5, 1'b1, 1'b1);  do_cycle("ld5en");
        check_val("ld5en.q_const", int'(q), 5);
        drive(1'b1, 4'd12, 1'b1, 1'b1); do_cycle("ldbad");
        check_val("ldbad.err_const", int'(load_err), 1);
        drive(1'b0, 4'd0, 1'b0, 1'b1);  do_cycle("ldbad_clear");
        check_val("ldbad_clear.err_const", int'(load_err), 0);

        // Excitation at 7 -> 8.
        drive(1'b1, 4'd7, 1'b0, 1'b1); do_cycle("ld7b");
        drive(1'b0, 4'd0, 1'b1, 1'b1);
        #1;
        check_val("exc78.j_const", int'(dut.j), 8);
        check_val("exc78.k_const", int'(dut.k), 7);
        do_cycle("exc78");

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 5) == 0), WIDTH'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), 1'($urandom));
            do_cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
